// File: rtl/if_id_queue.sv
// In-order fetch-to-decode instruction queue: 1-cycle write-to-read latency, no bypass.
// in_ready drops when full (no same-cycle pass-through); a taken branch flushes everything.
module if_id_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [31:0]   PC_in,
  input  logic [31:0]   Instruction_in,
  output logic          in_ready,
  input  logic          Br_taken,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   PC_out,
  output logic [31:0]   Instruction_out,
  output logic [AW:0]   count
);

  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [63:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;
  logic [63:0]   head;

  assign in_ready  = (count != FULL_CNT);
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready & ~Br_taken;
  assign pop       = out_valid & out_ready & ~Br_taken;

  // Empty queue reads as a NOP so decode never sees stale or uninitialised storage.
  assign head            = mem[rd_ptr];
  assign PC_out          = out_valid ? head[63:32] : 32'h0;
  assign Instruction_out = out_valid ? head[31:0]  : 32'h0;

  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem[wr_ptr] <= {PC_in, Instruction_in};
    end
  end

  always_ff @(posedge clk) begin
    if (rst || Br_taken) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule
